// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, key rotation schedule, S-boxes,
// controller state encoding and the permute helpers used by the datapath.
package des_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, OUT} state_t;

    localparam int NUM_ROUNDS = 16;

    localparam int SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_TAB [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    // Eight boxes of 4 rows x 16 columns, flattened box-major then row-major.
    localparam int SBOX_TAB [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

    // Tables list the source bit (1 = MSB) for each output position.
    function automatic logic [1:64] ip_perm(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 0; i < 64; i++) y[i+1] = x[IP_TAB[i]];
        return y;
    endfunction

    function automatic logic [1:64] fp_perm(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 0; i < 64; i++) y[i+1] = x[FP_TAB[i]];
        return y;
    endfunction

    function automatic logic [1:56] pc1_perm(input logic [1:64] x);
        logic [1:56] y;
        for (int i = 0; i < 56; i++) y[i+1] = x[PC1_TAB[i]];
        return y;
    endfunction

    function automatic logic [1:48] pc2_perm(input logic [1:56] x);
        logic [1:48] y;
        for (int i = 0; i < 48; i++) y[i+1] = x[PC2_TAB[i]];
        return y;
    endfunction

    function automatic logic [1:48] e_expand(input logic [1:32] x);
        logic [1:48] y;
        for (int i = 0; i < 48; i++) y[i+1] = x[E_TAB[i]];
        return y;
    endfunction

    function automatic logic [1:32] p_perm(input logic [1:32] x);
        logic [1:32] y;
        for (int i = 0; i < 32; i++) y[i+1] = x[P_TAB[i]];
        return y;
    endfunction

    // Outer bits pick the row, inner four bits pick the column.
    function automatic logic [1:4] sbox(input int s, input logic [1:6] b);
        int row;
        int col;
        row = int'({b[1], b[6]});
        col = int'(b[2:5]);
        return 4'(SBOX_TAB[s*64 + row*16 + col]);
    endfunction

    function automatic logic parity_err(input logic [1:64] k);
        logic err;
        err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (^k[8*i+1 +: 8] == 1'b0) err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/des_key_sched.sv
// C/D key schedule: PC-1 load, per-round rotation (left to encrypt, right to
// decrypt) and the PC-2 subkey for the round currently being computed.
module des_key_sched
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        mode,
    input  logic [4:0]  rnd,
    input  logic [1:64] key,
    output logic [1:48] subkey
);

    logic [1:28] c, d, c_rot, d_rot;
    int          shift_amt;

    // Decrypt walks the encrypt schedule backwards, starting from the
    // fully rotated (= original) C/D so round 1 needs no rotation.
    always_comb begin
        shift_amt = 0;
        if (rnd >= 5'd1 && rnd <= 5'(NUM_ROUNDS)) begin
            if (!mode)
                shift_amt = SHIFT_TAB[int'(rnd) - 1];
            else if (rnd != 5'd1)
                shift_amt = SHIFT_TAB[17 - int'(rnd)];
        end
        c_rot = c;
        d_rot = d;
        if (!mode) begin
            if (shift_amt == 1) begin
                c_rot = {c[2:28], c[1]};
                d_rot = {d[2:28], d[1]};
            end else if (shift_amt == 2) begin
                c_rot = {c[3:28], c[1:2]};
                d_rot = {d[3:28], d[1:2]};
            end
        end else begin
            if (shift_amt == 1) begin
                c_rot = {c[28], c[1:27]};
                d_rot = {d[28], d[1:27]};
            end else if (shift_amt == 2) begin
                c_rot = {c[27:28], c[1:26]};
                d_rot = {d[27:28], d[1:26]};
            end
        end
    end

    assign subkey = pc2_perm({c_rot, d_rot});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c <= '0;
            d <= '0;
        end else if (load) begin
            {c, d} <= pc1_perm(key);
        end else if (step) begin
            c <= c_rot;
            d <= d_rot;
        end
    end

endmodule

// File: rtl/f_function.sv
// DES round function: expansion, subkey mix, S-box substitution and P permutation.
module f_function
    import des_pkg::*;
(
    input  logic [1:32] RDatain,
    input  logic [1:48] Keyin,
    output logic [1:32] f_out
);

    logic [1:48] mixed;
    logic [1:32] sbox_out;

    always_comb begin
        mixed    = e_expand(RDatain) ^ Keyin;
        sbox_out = '0;
        for (int s = 0; s < 8; s++) begin
            sbox_out[4*s+1 +: 4] = sbox(s, mixed[6*s+1 +: 6]);
        end
    end

    assign f_out = p_perm(sbox_out);

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES controller: accepts a block, runs 16 rounds through one shared
// f_function and holds FP(R16||L16) on a valid/ready output until consumed.
module des_round_ctrl
    import des_pkg::*;
#(
    parameter bit PARITY_CHK = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mode,
    input  logic [1:64] din,
    input  logic [1:64] key,
    input  logic        abort,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:64] dout,
    output logic        key_err,
    output logic        busy
);

    state_t      state;
    logic [4:0]  rnd;
    logic [1:32] l, r, f_out;
    logic [1:48] subkey;
    logic        mode_r, key_err_r, out_valid_r, busy_r;
    logic        accept, rnd_ok, step, parity_bad;

    // Ready passes straight through in OUT so a new block can enter on the
    // same edge the previous result leaves.
    assign in_ready   = (state == IDLE) || (state == OUT && out_ready);
    assign accept     = in_valid && in_ready && !abort;
    assign rnd_ok     = (rnd >= 5'd1) && (rnd <= 5'(NUM_ROUNDS));
    assign step       = (state == ROUND) && rnd_ok && !abort;
    assign parity_bad = PARITY_CHK ? parity_err(key) : 1'b0;

    f_function u_f (
        .RDatain (r),
        .Keyin   (subkey),
        .f_out   (f_out)
    );

    des_key_sched u_key_sched (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .step   (step),
        .mode   (mode_r),
        .rnd    (rnd),
        .key    (key),
        .subkey (subkey)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rnd         <= '0;
            l           <= '0;
            r           <= '0;
            mode_r      <= 1'b0;
            key_err_r   <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (abort) begin
            state       <= IDLE;
            key_err_r   <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (accept) begin
            {l, r}      <= ip_perm(din);
            mode_r      <= mode;
            rnd         <= 5'd1;
            key_err_r   <= parity_bad;
            state       <= ROUND;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b1;
        end else begin
            case (state)
                ROUND: begin
                    if (!rnd_ok) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        l   <= r;
                        r   <= l ^ f_out;
                        rnd <= rnd + 5'd1;
                        if (rnd == 5'(NUM_ROUNDS)) begin
                            state       <= OUT;
                            out_valid_r <= 1'b1;
                            busy_r      <= 1'b0;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout      = fp_perm({r, l});
    assign key_err   = key_err_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed and randomized checks of des_round_ctrl against a table-driven DES
// reference model, with parity checking enabled and disabled.
module tb_des_round_ctrl;

    localparam int T_IP [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int T_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int T_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int T_E [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int T_P [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int T_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int T_SB [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

    logic        clk, rst_n, in_valid, mode, abort, out_ready;
    logic [63:0] din, key;
    logic        in_ready, out_valid, key_err, busy;
    logic [63:0] dout;
    logic        np_in_ready, np_out_valid, np_key_err, np_busy;
    logic [63:0] np_dout;
    int          errors = 0;
    int          checks = 0;

    des_round_ctrl #(.PARITY_CHK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .din(din), .key(key), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
        .key_err(key_err), .busy(busy));

    des_round_ctrl #(.PARITY_CHK(1'b0)) dut_np (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(np_in_ready),
        .mode(mode), .din(din), .key(key), .abort(abort),
        .out_valid(np_out_valid), .out_ready(out_ready), .dout(np_dout),
        .key_err(np_key_err), .busy(np_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit i of a w-bit value, numbered DES style (1 = MSB).
    function automatic logic getb(input logic [63:0] v, input int w, input int i);
        return v[w - i];
    endfunction

    function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] sb, res;
        int six, row, col;
        e = '0;
        for (int i = 0; i < 48; i++) e = {e[46:0], getb({32'b0, r}, 32, T_E[i])};
        e = e ^ k;
        sb = '0;
        for (int s = 0; s < 8; s++) begin
            six = int'((e >> (42 - 6*s)) & 48'h3F);
            row = ((six >> 4) & 2) | (six & 1);
            col = (six >> 1) & 15;
            sb  = {sb[27:0], 4'(T_SB[s*64 + row*16 + col])};
        end
        res = '0;
        for (int i = 0; i < 32; i++) res = {res[30:0], getb({32'b0, sb}, 32, T_P[i])};
        return res;
    endfunction

    // Decryption reuses the encryption subkeys in reverse order.
    function automatic logic [63:0] model_des(input logic [63:0] k, input logic [63:0] blk, input bit dec);
        logic [47:0] ks [16];
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [63:0] lr, res;
        logic [31:0] l, r, tmp;
        cd = '0;
        for (int i = 0; i < 56; i++) cd = {cd[54:0], getb(k, 64, T_PC1[i])};
        c = cd[55:28];
        d = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < T_SHIFT[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks[i] = '0;
            for (int j = 0; j < 48; j++) ks[i] = {ks[i][46:0], getb({8'b0, c, d}, 56, T_PC2[j])};
        end
        lr = '0;
        for (int i = 0; i < 64; i++) lr = {lr[62:0], getb(blk, 64, T_IP[i])};
        l = lr[63:32];
        r = lr[31:0];
        for (int i = 0; i < 16; i++) begin
            tmp = r;
            r   = l ^ model_f(r, dec ? ks[15-i] : ks[i]);
            l   = tmp;
        end
        lr  = {r, l};
        res = '0;
        for (int i = 0; i < 64; i++) res[64 - T_IP[i]] = lr[63 - i];
        return res;
    endfunction

    function automatic logic model_perr(input logic [63:0] k);
        for (int b = 0; b < 8; b++) begin
            if ($countones(k[8*b +: 8]) % 2 == 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input logic [63:0] k, input logic [63:0] d, input bit m);
        key = k;
        din = d;
        mode = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_output("busy_after_accept", 64'(busy), 64'd1);
    endtask

    // Waits for out_valid while scrambling the ignored inputs; bounded.
    task automatic run_rounds(output int lat);
        lat = 0;
        while (lat < 40) begin
            tick();
            lat++;
            if (out_valid) break;
            check_output("in_ready_round", 64'(in_ready), 64'd0);
            din = {$urandom, $urandom};
            key = {$urandom, $urandom};
            mode = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        #1;
        check_output("in_ready_out_ready", 64'(in_ready), 64'd1);
        tick();
        out_ready = 1'b0;
        check_output("out_valid_after_consume", 64'(out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        int ov_seen;
        logic [63:0] k, d, exp;
        bit m;

        rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; abort = 1'b0; out_ready = 1'b0;
        din = '0; key = '0;
        repeat (3) @(posedge clk);
        #2;
        check_output("rst_in_ready", 64'(in_ready), 64'd1);
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_dout", dout, 64'd0);
        check_output("rst_key_err", 64'(key_err), 64'd0);
        check_output("rst_np_in_ready", 64'(np_in_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        $display("[TB] encrypt known answer with backpressure");
        apply_stimulus(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0);
        run_rounds(lat);
        check_output("enc_latency", 64'(lat), 64'd16);
        check_output("enc_dout", dout, 64'h85E813540F0AB405);
        check_output("enc_key_err", 64'(key_err), 64'd0);
        for (int i = 0; i < 10; i++) begin
            din = {$urandom, $urandom};
            key = {$urandom, $urandom};
            mode = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            #1;
            check_output("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
            check_output("bp_out_valid", 64'(out_valid), 64'd1);
            check_output("bp_dout", dout, 64'h85E813540F0AB405);
        end
        in_valid = 1'b0;
        consume();

        $display("[TB] decrypt known answer");
        apply_stimulus(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1);
        run_rounds(lat);
        check_output("dec_latency", 64'(lat), 64'd16);
        check_output("dec_dout", dout, 64'h0123456789ABCDEF);
        consume();

        $display("[TB] back-to-back");
        out_ready = 1'b1;
        k = {$urandom, $urandom};
        d = {$urandom, $urandom};
        m = 1'($urandom_range(0, 1));
        apply_stimulus(64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0);
        run_rounds(lat);
        check_output("b2b_first_latency", 64'(lat), 64'd16);
        check_output("b2b_first_dout", dout, 64'h0);
        key = k; din = d; mode = m; in_valid = 1'b1;
        #1;
        check_output("b2b_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check_output("b2b_first_one_cycle", 64'(out_valid), 64'd0);
        check_output("b2b_second_busy", 64'(busy), 64'd1);
        run_rounds(lat);
        check_output("b2b_second_latency", 64'(lat), 64'd16);
        check_output("b2b_second_dout", dout, model_des(k, d, m));
        tick();
        check_output("b2b_second_one_cycle", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        $display("[TB] parity error key");
        apply_stimulus(64'h133457799BBCDFF0, 64'h0123456789ABCDEF, 1'b0);
        run_rounds(lat);
        check_output("par_key_err", 64'(key_err), 64'd1);
        check_output("par_np_key_err", 64'(np_key_err), 64'd0);
        check_output("par_dout", dout, model_des(64'h133457799BBCDFF0, 64'h0123456789ABCDEF, 1'b0));
        // abort in OUT with a ready handshake pending: no accept, key_err clears
        abort = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        tick();
        abort = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        check_output("abort_out_busy", 64'(busy), 64'd0);
        check_output("abort_out_valid", 64'(out_valid), 64'd0);
        check_output("abort_out_key_err", 64'(key_err), 64'd0);
        check_output("abort_out_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] randomized blocks");
        for (int n = 0; n < 8; n++) begin
            k = {$urandom, $urandom};
            d = {$urandom, $urandom};
            m = 1'($urandom_range(0, 1));
            exp = model_des(k, d, m);
            apply_stimulus(k, d, m);
            run_rounds(lat);
            check_output("rnd_latency", 64'(lat), 64'd16);
            check_output("rnd_dout", dout, exp);
            check_output("rnd_np_dout", np_dout, exp);
            check_output("rnd_np_out_valid", 64'(np_out_valid), 64'd1);
            check_output("rnd_key_err", 64'(key_err), 64'(model_perr(k)));
            check_output("rnd_np_key_err", 64'(np_key_err), 64'd0);
            consume();
        end

        $display("[TB] abort at round 7");
        apply_stimulus(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0);
        repeat (6) tick();
        abort = 1'b1; in_valid = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        check_output("abort_rnd_in_ready", 64'(in_ready), 64'd1);
        check_output("abort_rnd_busy", 64'(busy), 64'd0);
        ov_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) ov_seen++;
        end
        check_output("abort_rnd_no_out_valid", 64'(ov_seen), 64'd0);

        $display("[TB] asynchronous reset mid-round");
        apply_stimulus(64'h133457799BBCDFF0, 64'h0123456789ABCDEF, 1'b0);
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_output("arst_in_ready", 64'(in_ready), 64'd1);
        check_output("arst_busy", 64'(busy), 64'd0);
        check_output("arst_dout", dout, 64'd0);
        check_output("arst_key_err", 64'(key_err), 64'd0);
        #2;
        rst_n = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) ov_seen++;
        end
        check_output("arst_no_out_valid", 64'(ov_seen), 64'd0);
        apply_stimulus(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0);
        run_rounds(lat);
        check_output("post_rst_latency", 64'(lat), 64'd16);
        check_output("post_rst_dout", dout, 64'h85E813540F0AB405);
        consume();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
